// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: FSM state encoding, fault causes and the
// instruction-buffer payload.
package riscv_pkg;

   localparam int unsigned XLEN            = 32;
   localparam int unsigned TIMEOUT_DEFAULT = 255;

   // Fetch FSM states (legacy-compatible constant encoding)
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_REQ   = 3'd1;
   localparam logic [2:0] ST_WAIT  = 3'd2;
   localparam logic [2:0] ST_DRAIN = 3'd3;
   localparam logic [2:0] ST_HOLD  = 3'd4;
   localparam logic [2:0] ST_HALT  = 3'd5;

   // Fault cause carried with each buffered entry; NONE means a good fetch
   typedef logic [1:0] fault_t;
   localparam fault_t FAULT_NONE     = 2'd0;
   localparam fault_t FAULT_MISALIGN = 2'd1;
   localparam fault_t FAULT_BUS      = 2'd2;
   localparam fault_t FAULT_TIMEOUT  = 2'd3;

   typedef struct packed {
      logic [XLEN-1:0] data;
      logic [XLEN-1:0] addr;
      fault_t          cause;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Instruction output register for the fetch unit.
// Ports: clk/rst_n; load+entry captures a new instruction (wins over clear);
// clear empties the buffer after transfer or flush; show gates inst_valid
// combinationally so a same-cycle flush can retract it; inst_* go to decode;
// cause exposes the stored fault cause to the controller.
module fetch_buf
   import riscv_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  fetch_entry_t     entry,
   input  logic             clear,
   input  logic             show,
   output logic             inst_valid,
   output logic [XLEN-1:0]  inst_data,
   output logic [XLEN-1:0]  inst_addr,
   output logic             inst_fault,
   output fault_t           cause
);

   fetch_entry_t entry_q;
   logic         valid_q;

   // Contents stay stable until explicitly cleared or reloaded
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         entry_q <= '0;
         valid_q <= 1'b0;
      end else if (load) begin
         entry_q <= entry;
         valid_q <= 1'b1;
      end else if (clear) begin
         entry_q <= '0;
         valid_q <= 1'b0;
      end
   end

   assign inst_valid = valid_q & show;
   assign inst_data  = entry_q.data;
   assign inst_addr  = entry_q.addr;
   assign inst_fault = (entry_q.cause != FAULT_NONE);
   assign cause      = entry_q.cause;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding access at a time, with
// redirect flushing, misalign/bus/timeout faults and a halt-on-fault state.
// Ports: clk/rst_n; pc_addr/redirect from the PC, pc_advance back to it;
// mem_req/mem_addr/mem_gnt request channel; mem_rvalid/mem_rdata/mem_err
// response channel; inst_valid/inst_data/inst_addr/inst_fault/inst_ready
// decode handshake.
module fetch_ctrl
   import riscv_pkg::*;
#(
   parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT,
   parameter int unsigned RESET_HOLD = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [XLEN-1:0]  pc_addr,
   output logic             pc_advance,
   input  logic             redirect,
   output logic             mem_req,
   output logic [XLEN-1:0]  mem_addr,
   input  logic             mem_gnt,
   input  logic             mem_rvalid,
   input  logic [XLEN-1:0]  mem_rdata,
   input  logic             mem_err,
   output logic             inst_valid,
   output logic [XLEN-1:0]  inst_data,
   output logic [XLEN-1:0]  inst_addr,
   output logic             inst_fault,
   input  logic             inst_ready
);

   localparam int unsigned CNT_W = 8;
   // Terminal counts; counter value N-1 marks the Nth cycle in the state
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((RESET_HOLD > 0) ? RESET_HOLD - 1 : 0);

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0]  addr_q, addr_d;

   logic             ent_load, ent_clear, ent_show;
   fetch_entry_t     ent_d;
   fault_t           ent_cause;

   // State, counter and latched request address
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
      end
   end

   // Next-state and same-cycle handshake outputs
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      ent_load   = 1'b0;
      ent_clear  = 1'b0;
      ent_show   = 1'b0;
      ent_d      = '0;
      mem_req    = 1'b0;
      pc_advance = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cnt_q == HOLD_LAST) begin
               state_d = ST_REQ;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_REQ: begin
            if (!redirect) begin
               if (pc_addr[1:0] != 2'b00) begin
                  ent_load = 1'b1;
                  ent_d    = '{data: '0, addr: pc_addr, cause: FAULT_MISALIGN};
                  state_d  = ST_HOLD;
               end else begin
                  mem_req = 1'b1;
                  if (mem_gnt) begin
                     addr_d  = pc_addr;
                     cnt_d   = '0;
                     state_d = ST_WAIT;
                  end
               end
            end
         end

         ST_WAIT: begin
            if (mem_rvalid && redirect) begin
               // Response belongs to the abandoned path
               state_d = ST_REQ;
            end else if (mem_rvalid) begin
               ent_load = 1'b1;
               if (mem_err) begin
                  ent_d = '{data: '0, addr: addr_q, cause: FAULT_BUS};
               end else begin
                  ent_d      = '{data: mem_rdata, addr: addr_q, cause: FAULT_NONE};
                  pc_advance = 1'b1;
               end
               state_d = ST_HOLD;
            end else if (redirect) begin
               state_d = ST_DRAIN;
            end else if (cnt_q == TO_LAST) begin
               // Fault is parked in the buffer until the late response drains
               ent_load = 1'b1;
               ent_d    = '{data: '0, addr: addr_q, cause: FAULT_TIMEOUT};
               state_d  = ST_DRAIN;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_DRAIN: begin
            if (mem_rvalid) begin
               state_d = (ent_cause == FAULT_TIMEOUT) ? ST_HOLD : ST_REQ;
            end
         end

         ST_HOLD: begin
            ent_show = !redirect;
            if (redirect) begin
               ent_clear = 1'b1;
               state_d   = ST_REQ;
            end else if (inst_ready) begin
               ent_clear = 1'b1;
               state_d   = inst_fault ? ST_HALT : ST_REQ;
            end
         end

         ST_HALT: begin
            if (redirect) begin
               state_d = ST_REQ;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign mem_addr = mem_req ? pc_addr : '0;

   fetch_buf u_fetch_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (ent_load),
      .entry      (ent_d),
      .clear      (ent_clear),
      .show       (ent_show),
      .inst_valid (inst_valid),
      .inst_data  (inst_data),
      .inst_addr  (inst_addr),
      .inst_fault (inst_fault),
      .cause      (ent_cause)
   );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: per-cycle vector table plus a scoreboard of
// instructions expected to reach decode.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] pc_addr = '0;
   logic        pc_advance;
   logic        redirect = 1'b0;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        mem_err = 1'b0;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic [31:0] inst_addr;
   logic        inst_fault;
   logic        inst_ready = 1'b0;

   always #5 clk = ~clk;

   fetch_ctrl #(.TIMEOUT(4), .RESET_HOLD(1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pc_addr    (pc_addr),
      .pc_advance (pc_advance),
      .redirect   (redirect),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .mem_err    (mem_err),
      .inst_valid (inst_valid),
      .inst_data  (inst_data),
      .inst_addr  (inst_addr),
      .inst_fault (inst_fault),
      .inst_ready (inst_ready)
   );

   localparam int SB_NONE  = 0;
   localparam int SB_RESP  = 1;   // this cycle's response becomes an instruction
   localparam int SB_MIS   = 2;   // misaligned pc becomes a fault entry
   localparam int SB_TMO   = 3;   // timeout fault on the granted address
   localparam int SB_FLUSH = 4;   // buffered entry is dropped by redirect

   typedef struct {
      logic        rd;
      logic [31:0] pc;
      logic        gnt, rv, err;
      logic [31:0] rdata;
      logic        rdy;
      logic        x_req, x_adv, x_iv;
      logic [31:0] x_data, x_addr;
      logic        x_flt;
      int          sb;
   } vec_t;

   typedef struct packed {
      logic [31:0] data;
      logic [31:0] addr;
      logic        fault;
   } txn_t;

   int   errors = 0;
   int   checks = 0;
   txn_t sbq[$];
   logic [31:0] gaddr = '0;
   vec_t vecs[$];

   function automatic vec_t mk(input logic rd, input logic [31:0] pc,
                               input logic gnt, input logic rv, input logic err,
                               input logic [31:0] rdata, input logic rdy,
                               input logic xreq, input logic xadv, input logic xiv,
                               input logic [31:0] xdata, input logic [31:0] xaddr,
                               input logic xflt, input int sb);
      vec_t v;
      v.rd = rd; v.pc = pc; v.gnt = gnt; v.rv = rv; v.err = err;
      v.rdata = rdata; v.rdy = rdy;
      v.x_req = xreq; v.x_adv = xadv; v.x_iv = xiv;
      v.x_data = xdata; v.x_addr = xaddr; v.x_flt = xflt; v.sb = sb;
      return v;
   endfunction

   task automatic check_all_zero(input string name);
      checks++;
      if ({mem_req, mem_addr, pc_advance, inst_valid, inst_data, inst_addr, inst_fault} !== '0) begin
         errors++;
         $display("FAIL %s: req=%b addr=%h adv=%b iv=%b data=%h iaddr=%h flt=%b, want all 0",
                  name, mem_req, mem_addr, pc_advance, inst_valid, inst_data, inst_addr, inst_fault);
      end
   endtask

   task automatic apply(input vec_t v, input int idx);
      logic ok;
      txn_t t, e;
      @(posedge clk);
      #1;
      redirect = v.rd; pc_addr = v.pc; mem_gnt = v.gnt; mem_rvalid = v.rv;
      mem_err = v.err; mem_rdata = v.rdata; inst_ready = v.rdy;
      #3;
      checks++;
      ok = (mem_req === v.x_req) && (pc_advance === v.x_adv) && (inst_valid === v.x_iv);
      if (v.x_req && (mem_addr !== v.pc)) ok = 1'b0;
      if (v.x_iv && ({inst_data, inst_addr, inst_fault} !== {v.x_data, v.x_addr, v.x_flt})) ok = 1'b0;
      if (!ok) begin
         errors++;
         $display("FAIL vec%0d: got req=%b addr=%h adv=%b iv=%b data=%h iaddr=%h flt=%b; want req=%b addr=%h adv=%b iv=%b data=%h iaddr=%h flt=%b",
                  idx, mem_req, mem_addr, pc_advance, inst_valid, inst_data, inst_addr, inst_fault,
                  v.x_req, v.pc, v.x_adv, v.x_iv, v.x_data, v.x_addr, v.x_flt);
      end
      if (v.x_req && v.gnt) gaddr = v.pc;
      case (v.sb)
         SB_RESP:  begin t.data = v.err ? 32'h0 : v.rdata; t.addr = gaddr; t.fault = v.err; sbq.push_back(t); end
         SB_MIS:   begin t.data = 32'h0; t.addr = v.pc; t.fault = 1'b1; sbq.push_back(t); end
         SB_TMO:   begin t.data = 32'h0; t.addr = gaddr; t.fault = 1'b1; sbq.push_back(t); end
         SB_FLUSH: if (sbq.size() > 0) void'(sbq.pop_front());
         default:  ;
      endcase
      // Monitor: every accepted instruction must match the oldest expectation
      if (inst_valid && inst_ready) begin
         checks++;
         if (sbq.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected vec%0d: got data=%h addr=%h flt=%b, want no transfer",
                     idx, inst_data, inst_addr, inst_fault);
         end else begin
            e = sbq.pop_front();
            if ({inst_data, inst_addr, inst_fault} !== {e.data, e.addr, e.fault}) begin
               errors++;
               $display("FAIL sb_txn vec%0d: got data=%h addr=%h flt=%b, want data=%h addr=%h flt=%b",
                        idx, inst_data, inst_addr, inst_fault, e.data, e.addr, e.fault);
            end
         end
      end
   endtask

   initial begin
      //            rd   pc          gnt rv  err rdata        rdy  req adv iv  data         addr        flt sb
      // Fetch from 0, response one cycle after grant
      vecs.push_back(mk('0, 32'h0,    '1, '0, '0, 32'h0,       '0,  '1, '0, '0, 32'h0,       32'h0,      '0, SB_NONE));
      vecs.push_back(mk('0, 32'h0,    '0, '1, '0, 32'h13,      '0,  '0, '1, '0, 32'h0,       32'h0,      '0, SB_RESP));
      // Decode stalls five cycles, then accepts
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk('0, 32'h4, '1, '0, '0, 32'h0,       '0,  '0, '0, '1, 32'h13,      32'h0,      '0, SB_NONE));
      vecs.push_back(mk('0, 32'h4,    '0, '0, '0, 32'h0,       '1,  '0, '0, '1, 32'h13,      32'h0,      '0, SB_NONE));
      // Request held without grant, then granted
      vecs.push_back(mk('0, 32'h4,    '0, '0, '0, 32'h0,       '0,  '1, '0, '0, 32'h0,       32'h0,      '0, SB_NONE));
      vecs.push_back(mk('0, 32'h4,    '1, '0, '0, 32'h0,       '0,  '1, '0, '0, 32'h0,       32'h0,      '0, SB_NONE));
      // Redirect in WAIT; response three cycles later is drained
      vecs.push_back(mk('1, 32'h4,    '0, '0, '0, 32'h0,       '0,  '0, '0, '0, 32'h0,       32'h0,      '0, SB_NONE));
      vecs.push_back(mk('0, 32'h40,   '0, '0, '0, 32'h0,       '0,  '0, '0, '0, 32'h0,       32'h0,      '0, SB_NONE));
      vecs.push_back(mk('0, 32'h40,   '0, '0, '0, 32'h0,       '0,  '0, '0, '0, 32'h0,       32'h0,      '0, SB_NONE));
      vecs.push_back(mk('0, 32'h40,   '0, '1, '0, 32'hdead,    '0,  '0, '0, '0, 32'h0,       32'h0,      '0, SB_NONE));
      vecs.push_back(mk('0, 32'h40,   '1, '0, '0, 32'h0,       '0,  '1, '0, '0, 32'h0,       32'h0,      '0, SB_NONE));
      // Redirect coincides with response: dropped, back to REQ next cycle
      vecs.push_back(mk('1, 32'h40,   '0, '1, '0, 32'hbeef,    '1,  '0, '0, '0, 32'h0,       32'h0,      '0, SB_NONE));
      vecs.push_back(mk('0, 32'h80,   '0, '0, '0, 32'h0,       '1,  '1, '0, '0, 32'h0,       32'h0,      '0, SB_NONE));
      vecs.push_back(mk('1, 32'h80,   '0, '0, '0, 32'h0,       '0,  '0, '0, '0, 32'h0,       32'h0,      '0, SB_NONE));
      // Misaligned pc: fault entry, accept, HALT until redirect
      vecs.push_back(mk('0, 32'h45,   '1, '0, '0, 32'h0,       '0,  '0, '0, '0, 32'h0,       32'h0,      '0, SB_MIS));
      vecs.push_back(mk('0, 32'h45,   '0, '0, '0, 32'h0,       '0,  '0, '0, '1, 32'h0,       32'h45,     '1, SB_NONE));
      vecs.push_back(mk('0, 32'h45,   '0, '0, '0, 32'h0,       '1,  '0, '0, '1, 32'h0,       32'h45,     '1, SB_NONE));
      vecs.push_back(mk('0, 32'h45,   '1, '0, '0, 32'h0,       '1,  '0, '0, '0, 32'h0,       32'h0,      '0, SB_NONE));
      vecs.push_back(mk('0, 32'h45,   '1, '1, '0, 32'h0,       '1,  '0, '0, '0, 32'h0,       32'h0,      '0, SB_NONE));
      vecs.push_back(mk('1, 32'h45,   '0, '0, '0, 32'h0,       '0,  '0, '0, '0, 32'h0,       32'h0,      '0, SB_NONE));
      // Bus error: fault entry without pc_advance, then HALT
      vecs.push_back(mk('0, 32'h48,   '1, '0, '0, 32'h0,       '0,  '1, '0, '0, 32'h0,       32'h0,      '0, SB_NONE));
      vecs.push_back(mk('0, 32'h48,   '0, '1, '1, 32'hffffffff,'0,  '0, '0, '0, 32'h0,       32'h0,      '0, SB_RESP));
      vecs.push_back(mk('0, 32'h48,   '0, '0, '0, 32'h0,       '1,  '0, '0, '1, 32'h0,       32'h48,     '1, SB_NONE));
      vecs.push_back(mk('1, 32'h48,   '0, '0, '0, 32'h0,       '0,  '0, '0, '0, 32'h0,       32'h0,      '0, SB_NONE));
      // Good fetch flushed in HOLD by redirect (ready high but no transfer)
      vecs.push_back(mk('0, 32'h100,  '1, '0, '0, 32'h0,       '0,  '1, '0, '0, 32'h0,       32'h0,      '0, SB_NONE));
      vecs.push_back(mk('0, 32'h100,  '0, '1, '0, 32'h00100093,'0,  '0, '1, '0, 32'h0,       32'h0,      '0, SB_RESP));
      vecs.push_back(mk('1, 32'h104,  '0, '0, '0, 32'h0,       '1,  '0, '0, '0, 32'h0,       32'h0,      '0, SB_FLUSH));
      // Timeout after four WAIT cycles; late response drained, fault delivered
      vecs.push_back(mk('0, 32'h200,  '1, '0, '0, 32'h0,       '0,  '1, '0, '0, 32'h0,       32'h0,      '0, SB_NONE));
      for (int i = 0; i < 3; i++)
         vecs.push_back(mk('0, 32'h200, '0, '0, '0, 32'h0,     '0,  '0, '0, '0, 32'h0,       32'h0,      '0, SB_NONE));
      vecs.push_back(mk('0, 32'h200,  '0, '0, '0, 32'h0,       '0,  '0, '0, '0, 32'h0,       32'h0,      '0, SB_TMO));
      vecs.push_back(mk('0, 32'h200,  '0, '0, '0, 32'h0,       '0,  '0, '0, '0, 32'h0,       32'h0,      '0, SB_NONE));
      vecs.push_back(mk('1, 32'h200,  '0, '1, '0, 32'h55,      '0,  '0, '0, '0, 32'h0,       32'h0,      '0, SB_NONE));
      vecs.push_back(mk('0, 32'h200,  '0, '0, '0, 32'h0,       '0,  '0, '0, '1, 32'h0,       32'h200,    '1, SB_NONE));
      vecs.push_back(mk('0, 32'h200,  '0, '0, '0, 32'h0,       '1,  '0, '0, '1, 32'h0,       32'h200,    '1, SB_NONE));
      vecs.push_back(mk('0, 32'h200,  '1, '0, '0, 32'h0,       '0,  '0, '0, '0, 32'h0,       32'h0,      '0, SB_NONE));
      vecs.push_back(mk('1, 32'h200,  '0, '0, '0, 32'h0,       '0,  '0, '0, '0, 32'h0,       32'h0,      '0, SB_NONE));
      vecs.push_back(mk('0, 32'h300,  '1, '0, '0, 32'h0,       '0,  '1, '0, '0, 32'h0,       32'h0,      '0, SB_NONE));

      // Reset held with active-looking inputs: everything stays 0
      repeat (3) @(posedge clk);
      #1;
      pc_addr = 32'h0; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h13; inst_ready = 1'b1;
      #2;
      check_all_zero("reset_held");
      rst_n = 1'b1;
      #1;
      check_all_zero("idle_after_release");

      foreach (vecs[i]) apply(vecs[i], i);

      // Reset asserted mid-WAIT while a response is arriving
      @(posedge clk);
      #1;
      redirect = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h777; mem_err = 1'b0; inst_ready = 1'b1;
      #1;
      checks++;
      if (pc_advance !== 1'b1) begin
         errors++;
         $display("FAIL wait_before_reset: pc_advance=%b, want 1", pc_advance);
      end
      rst_n = 1'b0;
      #1;
      check_all_zero("async_reset_mid_wait");
      mem_rvalid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset_still_held");

      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover: %0d entries pending, want 0", sbq.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, is the number of WAIT cycles without mem_rvalid before an access fault is declared.
REQ-002 Parameter RESET_HOLD, default 1, is the number of cycles spent in IDLE after reset release before the first request.
REQ-003 Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 pc_addr  in  32  current PC from the program counter.
REQ-007 pc_advance  out  1  one-cycle pulse; steps the PC by 4 (drives the PC fetch-unit-valid input).
REQ-008 redirect  in  1  PC is loading a jump/branch target this cycle; new pc_addr is visible next cycle.
REQ-009 mem_req / mem_addr  out  1 / 32  instruction memory request and word address.
REQ-010 mem_gnt  in  1  request accepted this cycle.
REQ-011 mem_rvalid / mem_rdata / mem_err  in  1 / 32 / 1  response strobe, data and bus error.
REQ-012 inst_valid / inst_data / inst_addr / inst_fault  out  1 / 32 / 32 / 1  instruction to decode.
REQ-013 inst_ready  in  1  decode accepts the instruction when inst_valid && inst_ready.

Function
REQ-014 States: IDLE, REQ, WAIT, DRAIN, HOLD, HALT; at most one memory access is outstanding at any time.
REQ-015 IDLE counts RESET_HOLD cycles, then moves to REQ; all outputs are 0 in IDLE.
REQ-016 REQ drives mem_req=1 and mem_addr=pc_addr, unless redirect=1 or pc_addr[1:0]!=0.
REQ-017 In REQ, mem_gnt=1 latches pc_addr into the address register and moves to WAIT.
REQ-018 In REQ, redirect=1 suppresses mem_req and stays in REQ.
REQ-019 In REQ with pc_addr[1:0]!=0 and no redirect, the block issues no request, loads the buffer with inst_fault=1, inst_addr=pc_addr, inst_data=0, and moves to HOLD.
REQ-020 WAIT with mem_rvalid=1 and mem_err=0 loads the buffer (inst_data=mem_rdata, inst_addr=latched address, inst_fault=0), pulses pc_advance in the same cycle, and moves to HOLD.
REQ-021 WAIT with mem_rvalid=1 and mem_err=1 loads the buffer with inst_fault=1 and inst_data=0, does not pulse pc_advance, and moves to HOLD.
REQ-022 WAIT with redirect=1 and mem_rvalid=0 moves to DRAIN.
REQ-023 WAIT with redirect=1 and mem_rvalid=1 in the same cycle discards the response, does not pulse pc_advance, and moves to REQ.
REQ-024 The 8-bit WAIT counter resets on WAIT entry; when it reaches TIMEOUT, the block loads a fault entry and moves to DRAIN-then-HOLD, and the late response is discarded.
REQ-025 DRAIN discards the next mem_rvalid and then moves to REQ, or to HOLD if a fault entry is pending; redirect in DRAIN does not change the state.
REQ-026 HOLD drives inst_valid=1 with stable buffer contents until inst_ready=1.
REQ-027 HOLD with inst_ready=1 and inst_fault=0 moves to REQ; with inst_fault=1 it moves to HALT.
REQ-028 HOLD with redirect=1 clears inst_valid in the same cycle and moves to REQ, with no transfer.
REQ-029 HALT drives no outputs and leaves only on redirect, which moves to REQ.
REQ-030 pc_advance fires exactly once per successfully fetched instruction and never in the same cycle as redirect.

Reset
REQ-031 Reset forces IDLE; clears all outputs, the buffer, the WAIT counter and the address register to 0; and abandons any outstanding access with no drain.
REQ-032 Reset assertion takes effect without a clock edge; state advances only on clock edges after rst_n rises.

Structure
REQ-033 State encoding, the TIMEOUT default and the fault-cause constants (FAULT_MISALIGN, FAULT_BUS, FAULT_TIMEOUT) reside in shared package riscv_pkg.
REQ-034 The output register with valid/ready holding is sub-module fetch_buf; the FSM and counter stay in fetch_ctrl.

Verification
REQ-035 Reset release, pc_addr=0, mem_gnt=1 and mem_rvalid=1 one cycle later with rdata=0x00000013 -> mem_addr=0, then inst_valid=1, inst_data=0x13, inst_addr=0, one pc_advance pulse.
REQ-036 inst_ready=0 for 5 cycles in HOLD -> inst_valid stays 1 with stable data, no new mem_req, no pc_advance.
REQ-037 redirect in WAIT and rvalid 3 cycles later -> response dropped, no pc_advance, next mem_addr equals the new pc_addr (e.g. 0x40).
REQ-038 redirect in the same cycle as rvalid -> no inst_valid, no pc_advance, REQ entered the next cycle.
REQ-039 pc_addr=0x45 -> no mem_req, inst_fault=1, inst_addr=0x45; after acceptance HALT until redirect to 0x48.
REQ-040 TIMEOUT=4 with no rvalid -> inst_fault=1 after 4 WAIT cycles; a late rvalid is dropped; rst_n low mid-WAIT -> all outputs 0 immediately.
